// File: rtl/remote_key_if.sv
// Key-queue handshake bundle between the IR frame decoder, the key FIFO and its consumer.
// master = decoder/consumer side, slave = remote_key_fifo.
interface remote_key_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    Tecla;
    logic          Ready;
    logic [7:0]    KeyOut;
    logic          KeyValid;
    logic          KeyAck;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          ClearOvf;

    modport master (
        output Tecla, Ready, KeyAck, ClearOvf,
        input  KeyOut, KeyValid, Count, Overflow
    );

    modport slave (
        input  Tecla, Ready, KeyAck, ClearOvf,
        output KeyOut, KeyValid, Count, Overflow
    );
endinterface

// File: rtl/remote_key_fifo.sv
// First-word-fall-through queue of decoded IR key codes, one entry per Ready rising edge.
// Optional repeat filter enabled by defining REPEAT_FILTER_EN (uses HOLDOFF).
module remote_key_fifo #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    remote_key_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_q;
    logic          overflow;

    logic ev;
    logic cand;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign ev   = bus.Ready && !ready_q;
    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) && bus.KeyAck;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

`ifdef REPEAT_FILTER_EN
    localparam int HW = $clog2(HOLDOFF + 1);

    logic [7:0]    last_key;
    logic [HW-1:0] hold_cnt;
    logic          repeat_hit;

    assign repeat_hit = ev && (bus.Tecla == last_key) && (hold_cnt != '0);
    assign cand       = ev && !repeat_hit;

    // Every event restarts the window, so a held key stays suppressed.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_key <= 8'h00;
            hold_cnt <= '0;
        end else if (ev) begin
            hold_cnt <= HW'(HOLDOFF);
            if (!repeat_hit)
                last_key <= bus.Tecla;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end
`else
    logic unused_holdoff;

    assign unused_holdoff = (HOLDOFF != 0);
    assign cand           = ev;
`endif

    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr] <= bus.Tecla;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ready_q <= bus.Ready;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (bus.ClearOvf)
                overflow <= 1'b0;
        end
    end

    assign bus.KeyValid = (count != '0);
    assign bus.KeyOut   = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.Count    = count;
    assign bus.Overflow = overflow;
endmodule
